// File: rtl/prio_pkg.sv
// ----------------------------------------------------------------------------
// prio_pkg
// Shared constants for the priority arbiter / encoder:
//   MODE_FIXED / MODE_RR : values of the 'mode' input
//   ST_IDLE / ST_HOLD    : encoding of the two-state grant FSM
//   safe_width()         : index width for an N-input request vector; never
//                          returns 0, so N=2 still gets a 1-bit index
// ----------------------------------------------------------------------------
package prio_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    function automatic int safe_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_scan.sv
// ----------------------------------------------------------------------------
// prio_scan
// Combinational winner search over a request vector.
//   req    [N-1:0] : request lines
//   start  [W-1:0] : first index examined in round-robin mode (must be < N)
//   mode           : MODE_FIXED (highest index wins) or MODE_RR (rotated scan)
//   any            : at least one request is set
//   idx    [W-1:0] : winning index (0 when no request)
//   onehot [N-1:0] : one-hot form of idx (all zeros when no request)
// ----------------------------------------------------------------------------
module prio_scan
    import prio_pkg::*;
#(
    parameter int N = 8,
    parameter int W = safe_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic         any,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    // Concatenating req with itself lets the rotated scan run as a straight
    // walk from 'start' over N consecutive bits, with no modulo inside the
    // loop. Offsets are walked from far to near so the nearest set bit is
    // the last assignment and therefore wins. A position in the upper copy
    // maps back to its index by subtracting N.
    logic [2*N-1:0] dbl;

    always_comb begin
        dbl = {req, req};
        any = |req;
        idx = '0;
        if (mode == MODE_RR) begin
            for (int off = N - 1; off >= 0; off--) begin
                if (dbl[int'(start) + off]) begin
                    if (int'(start) + off >= N) begin
                        idx = W'(int'(start) + off - N);
                    end else begin
                        idx = W'(int'(start) + off);
                    end
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    idx = W'(i);
                end
            end
        end
    end

    assign onehot = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/prio_arb_enc.sv
// ----------------------------------------------------------------------------
// prio_arb_enc
// Registered N-input priority encoder / arbiter with a valid/ready output.
//   clk, rst_n           : clock, asynchronous active-low reset
//   mode                 : 0 = fixed priority (req[N-1] highest), 1 = round-robin
//   req        [N-1:0]   : level-sensitive request vector
//   out_ready            : consumer accepts the presented grant
//   out_valid            : a grant is being presented
//   out_idx    [W-1:0]   : encoded winning index
//   out_onehot [N-1:0]   : one-hot form of out_idx, zero while out_valid is 0
// A grant is held unchanged until accepted; on acceptance the next winner
// may be loaded in the same cycle, giving one grant per clock.
// ----------------------------------------------------------------------------
module prio_arb_enc
    import prio_pkg::*;
#(
    parameter int N = 8,
    parameter int W = safe_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot
);

    logic         state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;

    logic         accept;
    logic [W-1:0] ptr_acc;
    logic [W-1:0] scan_start;
    logic         scan_any;
    logic [W-1:0] scan_idx;
    logic [N-1:0] scan_onehot;

    // When the held grant is accepted this cycle, the pointer has already
    // conceptually moved past it, so the back-to-back winner must be
    // searched from the post-accept pointer rather than the stored one.
    // The wrap compares against N-1 so non-power-of-two N stays exact.
    always_comb begin
        accept     = (state_q == ST_HOLD) && out_ready;
        ptr_acc    = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
        scan_start = accept ? ptr_acc : ptr_q;
    end

    prio_scan #(
        .N (N),
        .W (W)
    ) u_scan (
        .req    (req),
        .start  (scan_start),
        .mode   (mode),
        .any    (scan_any),
        .idx    (scan_idx),
        .onehot (scan_onehot)
    );

    // IDLE loads the first winner; HOLD freezes everything until accepted,
    // then either reloads (back-to-back) or drops to IDLE clearing the
    // one-hot output.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        if (state_q == ST_IDLE) begin
            if (scan_any) begin
                state_d  = ST_HOLD;
                idx_d    = scan_idx;
                onehot_d = scan_onehot;
            end
        end else if (out_ready) begin
            ptr_d = ptr_acc;
            if (scan_any) begin
                idx_d    = scan_idx;
                onehot_d = scan_onehot;
            end else begin
                state_d  = ST_IDLE;
                onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    assign out_valid  = (state_q == ST_HOLD);
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;

endmodule

// File: tb/tb_prio_arb_enc.sv
// ----------------------------------------------------------------------------
// tb_prio_arb_enc
// Self-checking bench for prio_arb_enc with two instances: N=8 and N=5.
// Stimulus pushes hand-computed grant indices into per-instance queues; a
// monitor on each instance pops and compares on every accepted transfer.
// Reset values and held outputs are checked directly by the stimulus.
// ----------------------------------------------------------------------------
module tb_prio_arb_enc;

    logic       clk;
    logic       rst_n;

    logic       mode8, ready8;
    logic [7:0] req8;
    logic       valid8;
    logic [2:0] idx8;
    logic [7:0] onehot8;

    logic       mode5, ready5;
    logic [4:0] req5;
    logic       valid5;
    logic [2:0] idx5;
    logic [4:0] onehot5;

    int checks = 0;
    int errors = 0;

    int exp8_q[$];
    int exp5_q[$];
    int e8, e5;

    prio_arb_enc #(.N(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode8),
        .req        (req8),
        .out_ready  (ready8),
        .out_valid  (valid8),
        .out_idx    (idx8),
        .out_onehot (onehot8)
    );

    prio_arb_enc #(.N(5)) u_dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode5),
        .req        (req5),
        .out_ready  (ready5),
        .out_valid  (valid5),
        .out_idx    (idx5),
        .out_onehot (onehot5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic m, input logic [7:0] r, input logic rdy);
        mode8  = m;
        req8   = r;
        ready8 = rdy;
    endtask

    // Monitors: a transfer happens on the coming edge when valid && ready
    // are seen at the falling edge.
    always @(negedge clk) begin
        if (rst_n && valid8 && ready8) begin
            checks++;
            if (exp8_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL n8_grant: got idx %0d expected no transfer", idx8);
            end else begin
                e8 = exp8_q.pop_front();
                if (idx8 !== 3'(e8) || onehot8 !== (8'd1 << e8)) begin
                    errors++;
                    $display("[TB] FAIL n8_grant: got idx %0d onehot %b expected idx %0d onehot %b",
                             idx8, onehot8, e8, 8'd1 << e8);
                end
            end
        end
        if (rst_n && valid5 && ready5) begin
            checks++;
            if (exp5_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL n5_grant: got idx %0d expected no transfer", idx5);
            end else begin
                e5 = exp5_q.pop_front();
                if (idx5 !== 3'(e5) || onehot5 !== (5'd1 << e5)) begin
                    errors++;
                    $display("[TB] FAIL n5_grant: got idx %0d onehot %b expected idx %0d onehot %b",
                             idx5, onehot5, e5, 5'd1 << e5);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        apply_stimulus(1'b0, 8'h00, 1'b0);
        mode5 = 1'b0; req5 = 5'h00; ready5 = 1'b0;
        step();
        step();
        check_output("reset_valid", 32'(valid8), 32'd0);
        check_output("reset_idx", 32'(idx8), 32'd0);
        check_output("reset_onehot", 32'(onehot8), 32'd0);
        rst_n = 1'b1;

        // Fixed priority: bits 0 and 2 set, 2 wins.
        apply_stimulus(1'b0, 8'b0000_0101, 1'b1);
        step();
        check_output("fixed_valid", 32'(valid8), 32'd1);
        check_output("fixed_idx", 32'(idx8), 32'd2);
        check_output("fixed_onehot", 32'(onehot8), 32'h04);

        // Back-pressure: grant 2 stays put while req changes.
        apply_stimulus(1'b0, 8'h80, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("hold_idx", 32'(idx8), 32'd2);
            check_output("hold_valid", 32'(valid8), 32'd1);
        end
        check_output("hold_onehot", 32'(onehot8), 32'h04);
        exp8_q.push_back(2);
        ready8 = 1'b1;
        step();
        check_output("after_accept_idx", 32'(idx8), 32'd7);
        exp8_q.push_back(7);
        req8 = 8'h00;
        step();
        check_output("drain_valid", 32'(valid8), 32'd0);
        check_output("drain_onehot", 32'(onehot8), 32'd0);
        ready8 = 1'b0;

        // Reset to clear the pointer, then round-robin over all requests.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        foreach (exp8_q[i]) check_output("queue_empty_before_rr", 32'(exp8_q.size()), 32'd0);
        begin
            int seq[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 0, 1};
            foreach (seq[i]) exp8_q.push_back(seq[i]);
        end
        apply_stimulus(1'b1, 8'hFF, 1'b1);
        step();
        check_output("rr_first_idx", 32'(idx8), 32'd0);
        for (int i = 0; i < 13; i++) step();
        check_output("rr_before_wrap_idx", 32'(idx8), 32'd5);
        // Pointer is 6 after accepting 5: scan 6,7 then wraps to 0.
        req8 = 8'b0000_0011;
        step();
        check_output("rr_wrap_idx", 32'(idx8), 32'd0);
        step();
        check_output("rr_after_wrap_idx", 32'(idx8), 32'd1);
        req8 = 8'h00;
        step();
        check_output("rr_drain_valid", 32'(valid8), 32'd0);
        step();
        check_output("ready_while_idle_valid", 32'(valid8), 32'd0);
        ready8 = 1'b0;

        // N=5 round-robin: 0 and 4 alternate, pointer wraps 4 -> 0.
        exp5_q.push_back(0);
        exp5_q.push_back(4);
        exp5_q.push_back(0);
        exp5_q.push_back(4);
        mode5 = 1'b1; req5 = 5'b10001; ready5 = 1'b1;
        step();
        check_output("n5_first_idx", 32'(idx5), 32'd0);
        step();
        check_output("n5_second_idx", 32'(idx5), 32'd4);
        step();
        step();
        req5 = 5'h00;
        step();
        for (int i = 0; i < 3; i++) begin
            check_output("n5_idle_valid", 32'(valid5), 32'd0);
            step();
        end
        ready5 = 1'b0;

        // Asynchronous reset in the middle of a held grant.
        apply_stimulus(1'b0, 8'h08, 1'b0);
        step();
        check_output("pre_reset_idx", 32'(idx8), 32'd3);
        check_output("pre_reset_valid", 32'(valid8), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_output("async_reset_valid", 32'(valid8), 32'd0);
        check_output("async_reset_idx", 32'(idx8), 32'd0);
        check_output("async_reset_onehot", 32'(onehot8), 32'd0);
        apply_stimulus(1'b1, 8'hFF, 1'b0);
        step();
        rst_n = 1'b1;
        exp8_q.push_back(0);
        step();
        check_output("post_reset_idx", 32'(idx8), 32'd0);
        apply_stimulus(1'b1, 8'h00, 1'b1);
        step();
        check_output("post_reset_drain_valid", 32'(valid8), 32'd0);
        ready8 = 1'b0;
        step();

        check_output("n8_queue_left", 32'(exp8_q.size()), 32'd0);
        check_output("n5_queue_left", 32'(exp5_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_arb_enc.md
# prio_arb_enc

Parametrised, registered N-input priority encoder with a valid/ready output handshake and a selectable fixed-priority or round-robin mode. It generalises the 4-to-2 combinational priority encoder into a sequential arbitration front-end. It sits between a bank of request lines and a single consumer that accepts one encoded index at a time. The block holds its grant stable under back-pressure and supports back-to-back grants.

## Interface

Parameters:
- `N`, default 8: number of request inputs; legal range 2..256.
- `W`, default `$clog2(N)`: index width; derived, never overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = fixed priority, 1 = round-robin; sampled only in cycles where a new grant is loaded.
- `req`  in  N  request vector; level-sensitive, no handshake on the input side.
- `out_ready`  in  1  consumer accepts the current grant.
- `out_valid`  out  1  grant register holds a valid index.
- `out_idx`  out  W  encoded winning index.
- `out_onehot`  out  N  one-hot form of `out_idx`; all zeros when `out_valid` = 0.

## Operation

- **Fixed mode.** The highest set index wins; `req[N-1]` has top priority.
- **Round-robin mode.**
  - A W-bit pointer `ptr` sets the search start.
  - The winner is the first set bit scanning `ptr`, `ptr+1`, …, `N-1`, `0`, …, `ptr-1`.
- **Pointer update.**
  - On each accepted grant (`out_valid && out_ready`), `ptr` becomes (`out_idx`+1) mod N, in both modes.
  - Wrap uses an explicit compare against N-1, not a power-of-2 overflow, so non-power-of-2 N is exact.
- **State machine (2 states).**
  - IDLE: `out_valid`=0. If `req` != 0, load the winner into `out_idx`/`out_onehot` and go to HOLD. Otherwise stay in IDLE.
  - HOLD: `out_valid`=1. Outputs are frozen while `out_ready`=0, regardless of changes on `req` or `mode`.
  - HOLD with `out_ready`=1 and `req` != 0: load the next winner in the same cycle and stay in HOLD (back-to-back). Arbitration uses the updated pointer, i.e. (accepted `out_idx`+1) mod N.
  - HOLD with `out_ready`=1 and `req` == 0: go to IDLE.
- **Dropped requests.** A request that drops while its grant is held is still presented until accepted; no retraction.
- **Mode switching.** A `mode` change takes effect at the next grant load. The pointer keeps its value across mode changes.
- **Reset.** `rst_n` low forces IDLE, `out_valid`=0, `out_idx`=0, `out_onehot`=0 and `ptr`=0, asynchronously at any point, including mid-HOLD. Release is synchronous to `clk`.

## Timing

- **Latency.** `req` sampled at edge k produces `out_valid`=1 with the index after edge k, visible in cycle k+1.
- **Throughput.** One grant per cycle when `out_ready` is held at 1 and `req` != 0.
- **Output source.** `out_valid`, `out_idx` and `out_onehot` are registered; no combinational path from `req` or `out_ready` to any output.
- **Handshake rule.** A transfer occurs on an edge where `out_valid && out_ready`. `out_ready` may be high while `out_valid`=0 with no effect.
- **Reset values.** `out_valid`=0, `out_idx`=0, `out_onehot`=0, internal `ptr`=0, state=IDLE.

## Structure

- **Shared package `prio_pkg`.**
  - Mode constants `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1.
  - State encoding `ST_IDLE` / `ST_HOLD`.
  - Function for safe index width (returns 1 when N=2 edge cases are evaluated).
- **Sub-module `prio_scan`.**
  - Purely combinational.
  - Inputs: `req[N-1:0]`, `start[W-1:0]`, `mode`.
  - Outputs: `any`, `idx[W-1:0]`, `onehot[N-1:0]`.
  - Implements both fixed and rotated search with a doubled-vector mask.
- **Top level.** `prio_arb_enc` holds the FSM, the pointer and the output registers.

## Test plan

1. N=8, fixed, `req`=8'b0000_0101, `out_ready`=1 → next cycle `out_valid`=1, `out_idx`=2, `out_onehot`=8'b0000_0100.
2. Back-pressure: with `out_idx`=2 held and `out_ready`=0, `req` changes to 8'h80 → outputs stay 2 for 5 cycles. On the `out_ready`=1 edge → `out_idx`=7 next cycle.
3. N=8, RR, `req`=8'hFF held, `out_ready`=1 from reset → `out_idx` sequence 0,1,2,…,7,0,1 at one grant per cycle.
4. RR wrap: after grant of 5 (`ptr`=6), `req`=8'b0000_0011 → `out_idx`=0; then `ptr`=1 and the next grant is 1.
5. N=5, RR, `req`=5'b10001 → grants alternate 0,4,0,4, with the pointer wrapping 4→0. `req`=0 → `out_valid` falls after the last accept and stays 0.
6. Reset mid-HOLD: `rst_n` low while `out_valid`=1, `out_idx`=3 → `out_valid`=0 and `out_idx`=0 immediately, without waiting for a clock edge. After release with `req`=8'hFF in RR → first grant is 0.
